// File: rtl/subtract_mean_hls_deadlock_reporter.sv
// Deadlock reporter sitting downstream of the idx0 deadlock monitor.
// Declares deadlock once block_in has been high for THRESHOLD consecutive
// cycles. It then holds a report until that report is acknowledged, and
// keeps the deadlock flag sticky until clear or reset.
// Optional build macro SUBTRACT_MEAN_DEADLOCK_SNAPSHOT_EN adds the
// free-running cycle stamp and the report_axis/report_cycles capture
// registers. Without it, both report fields read as zero.
module subtract_mean_hls_deadlock_reporter #(
  parameter int THRESHOLD = 1000,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             block_in,
  input  logic [2:0]       axis_block_sigs,
  input  logic             clear,
  input  logic             report_ack,
  output logic             deadlock_detected,
  output logic             report_valid,
  output logic [2:0]       report_axis,
  output logic [CNT_W-1:0] report_cycles
);

  typedef enum logic [1:0] {IDLE, COUNT, REPORT, HOLD} state_t;

  // Last count value before detection; block_in high with cnt at this value
  // is the THRESHOLD-th consecutive sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             detect;

  // Detection edge: shared by the FSM and the snapshot capture so both agree.
  assign detect = (state == COUNT) && block_in && (cnt == CNT_LAST) && !clear;

  // Control FSM with registered flags; clear overrides report_ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      deadlock_detected <= 1'b0;
      report_valid      <= 1'b0;
    end else if (clear) begin
      state             <= IDLE;
      cnt               <= '0;
      deadlock_detected <= 1'b0;
      report_valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (block_in) begin
            state <= COUNT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        COUNT: begin
          if (!block_in) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (detect) begin
            state             <= REPORT;
            cnt               <= '0;
            deadlock_detected <= 1'b1;
            report_valid      <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPORT: begin
          if (report_ack) begin
            state        <= HOLD;
            report_valid <= 1'b0;
          end
        end
        HOLD: begin
          // Sticky until clear or reset; block_in is not counted here.
          state <= HOLD;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SUBTRACT_MEAN_DEADLOCK_SNAPSHOT_EN
  logic [CNT_W-1:0] stamp;

  // Free-running cycle stamp, saturating at all-ones rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset)
      stamp <= '0;
    else if (stamp != '1)
      stamp <= stamp + CNT_W'(1);
  end

  // Snapshot of the stream flags and stamp on the detection edge; held through clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      report_axis   <= '0;
      report_cycles <= '0;
    end else if (detect) begin
      report_axis   <= axis_block_sigs;
      report_cycles <= stamp;
    end
  end
`else
  logic unused_axis;

  assign report_axis   = '0;
  assign report_cycles = '0;
  assign unused_axis   = ^axis_block_sigs;
`endif

endmodule

// File: tb/tb_subtract_mean_hls_deadlock_reporter.sv
// Directed bench for subtract_mean_hls_deadlock_reporter at THRESHOLD=4.
// Expected report fields follow SUBTRACT_MEAN_DEADLOCK_SNAPSHOT_EN: with the
// macro, they are the captured values; without it, they are zero.
module tb_subtract_mean_hls_deadlock_reporter;

  localparam int CNT_W = 16;

`ifdef SUBTRACT_MEAN_DEADLOCK_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             block_in;
  logic [2:0]       axis_block_sigs;
  logic             clear;
  logic             report_ack;
  logic             deadlock_detected;
  logic             report_valid;
  logic [2:0]       report_axis;
  logic [CNT_W-1:0] report_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  subtract_mean_hls_deadlock_reporter #(.THRESHOLD(4), .CNT_W(CNT_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .block_in          (block_in),
    .axis_block_sigs   (axis_block_sigs),
    .clear             (clear),
    .report_ack        (report_ack),
    .deadlock_detected (deadlock_detected),
    .report_valid      (report_valid),
    .report_axis       (report_axis),
    .report_cycles     (report_cycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit past it before sampling or driving.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Reset sampled high on one edge; the next edge is "cycle 0".
  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic dd, input logic rv);
    check({tag, "_dd"}, {31'd0, deadlock_detected}, {31'd0, dd});
    check({tag, "_rv"}, {31'd0, report_valid}, {31'd0, rv});
  endtask

  task automatic check_report(input string tag, input logic [2:0] ax, input int cyc);
    check({tag, "_axis"}, {29'd0, report_axis}, SNAP ? {29'd0, ax} : 32'd0);
    check({tag, "_cyc"}, {16'd0, report_cycles}, SNAP ? cyc : 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    block_in        = 1'b0;
    axis_block_sigs = 3'b000;
    clear           = 1'b0;
    report_ack      = 1'b0;
    #2;
    tick(2);
    check_flags("reset", 1'b0, 1'b0);
    check_report("reset", 3'b000, 0);

    // Basic detection: block_in high from cycle 10, with capture at edge 13.
    reset = 1'b0;
    tick(10);
    block_in        = 1'b1;
    axis_block_sigs = 3'b010;
    tick(3);
    check_flags("pre_detect", 1'b0, 1'b0);
    tick(1);
    check_flags("detect14", 1'b1, 1'b1);
    check_report("detect14", 3'b010, 13);

    // The report is held with stable fields until ack at cycle 20.
    axis_block_sigs = 3'b111;
    tick(6);
    check_flags("report_hold", 1'b1, 1'b1);
    check_report("report_hold", 3'b010, 13);
    report_ack = 1'b1;
    tick(1);
    report_ack = 1'b0;
    check_flags("ack21", 1'b1, 1'b0);

    // HOLD: deadlock flag stays sticky while block_in toggles; ack is ignored.
    for (int i = 0; i < 6; i++) begin
      block_in   = i[0];
      report_ack = i[1];
      tick(1);
      check_flags("hold_toggle", 1'b1, 1'b0);
    end
    report_ack = 1'b0;

    // Clear returns to IDLE and keeps the snapshot fields.
    block_in = 1'b0;
    clear    = 1'b1;
    tick(1);
    clear = 1'b0;
    check_flags("clear", 1'b0, 1'b0);
    check_report("clear_keep", 3'b010, 13);

    // Interrupted run: high for 10-12, low at 13, high from 14; detect after edge 17.
    do_reset();
    check_report("reset2", 3'b000, 0);
    axis_block_sigs = 3'b101;
    tick(10);
    block_in = 1'b1;
    tick(3);
    block_in   = 1'b0;
    report_ack = 1'b1;  // ack while counting/idle is ignored
    tick(1);
    report_ack = 1'b0;
    block_in   = 1'b1;
    tick(1);
    check_flags("gap14", 1'b0, 1'b0);
    tick(2);
    check_flags("gap17", 1'b0, 1'b0);
    tick(1);
    check_flags("gap18", 1'b1, 1'b1);
    check_report("gap18", 3'b101, 17);

    // Clear and ack together in REPORT: clear wins, with no HOLD entry.
    clear      = 1'b1;
    report_ack = 1'b1;
    tick(1);
    clear      = 1'b0;
    report_ack = 1'b0;
    check_flags("clr_ack", 1'b0, 1'b0);
    check_report("clr_ack_keep", 3'b101, 17);
    // From IDLE, a fresh 4-cycle run must detect again (HOLD would hold dd=1, rv=0).
    axis_block_sigs = 3'b011;
    tick(3);
    check_flags("rerun3", 1'b0, 1'b0);
    tick(1);
    check_flags("rerun4", 1'b1, 1'b1);
    check_report("rerun4", 3'b011, 22);

    // Reset mid-COUNT (cnt=2): all outputs clear, and counting restarts from zero.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    axis_block_sigs = 3'b110;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_flags("rst_mid", 1'b0, 1'b0);
    check_report("rst_mid", 3'b000, 0);
    tick(3);
    check_flags("rst_run3", 1'b0, 1'b0);
    tick(1);
    check_flags("rst_run4", 1'b1, 1'b1);
    check_report("rst_run4", 3'b110, 3);

    // Reset mid-REPORT has priority over a simultaneous clear and ack.
    reset      = 1'b1;
    clear      = 1'b1;
    report_ack = 1'b1;
    tick(1);
    reset      = 1'b0;
    clear      = 1'b0;
    report_ack = 1'b0;
    block_in   = 1'b0;
    check_flags("rst_report", 1'b0, 1'b0);
    check_report("rst_report", 3'b000, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/subtract_mean_hls_deadlock_reporter.md
SUBTRACT_MEAN_HLS_DEADLOCK_REPORTER -- requirements
Module: subtract_mean_hls_deadlock_reporter

Interface
REQ-001 Parameter THRESHOLD, default 1000, consecutive block-high cycles required to declare deadlock; legal range 2 to 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 16, width of the persistence counter and cycle stamp.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 block_in  input  1  block flag from the idx0 deadlock monitor, consumed directly downstream of it.
REQ-006 axis_block_sigs  input  3  per-stream AXIS block flags, the same vector the monitor receives.
REQ-007 clear  input  1  software/testbench clear of a latched deadlock.
REQ-008 report_ack  input  1  consumer accepts the report.
REQ-009 deadlock_detected  output  1  sticky deadlock flag.
REQ-010 report_valid  output  1  report pending.
REQ-011 report_axis  output  3  snapshot of axis_block_sigs at detection.
REQ-012 report_cycles  output  CNT_W  free-running cycle stamp at detection.

Function
REQ-013 FSM states IDLE, COUNT, REPORT and HOLD; the state is registered and only one state is active per cycle.
REQ-014 IDLE: block_in=1 -> COUNT with cnt=1; otherwise stay in IDLE with cnt=0.
REQ-015 COUNT: block_in=0 -> IDLE with cnt=0; block_in=1 and cnt=THRESHOLD-1 -> REPORT; otherwise cnt+1.
REQ-016 On entry to REPORT: deadlock_detected=1, report_valid=1, report_axis and report_cycles captured from the current-cycle inputs/stamp.
REQ-017 Latency: after block_in is sampled high on THRESHOLD consecutive edges, deadlock_detected is high on the cycle following the THRESHOLD-th sampling edge.
REQ-018 REPORT: report_valid holds with stable report_axis/report_cycles until report_ack=1 is sampled; then -> HOLD, report_valid=0 next cycle.
REQ-019 HOLD: deadlock_detected stays 1 whatever block_in does; block_in is not counted.
REQ-020 clear=1 in any state -> IDLE next cycle; deadlock_detected, report_valid and cnt clear; report_axis and report_cycles retain their values.
REQ-021 clear and report_ack high together: clear wins; no HOLD entry.
REQ-022 report_ack outside REPORT is ignored.
REQ-023 Cycle stamp increments every cycle from 0 and saturates at 2^CNT_W-1; it never wraps.
REQ-024 The persistence counter never exceeds THRESHOLD-1; a single low cycle of block_in restarts counting from zero.

Reset
REQ-025 reset=1: state=IDLE, cnt=0, stamp=0; deadlock_detected=0, report_valid=0, report_axis=0, report_cycles=0 on the next edge.
REQ-026 Reset has priority over clear, report_ack and block_in, including mid-COUNT and mid-REPORT.

Configuration
REQ-027 Macro SUBTRACT_MEAN_DEADLOCK_SNAPSHOT_EN: when defined, the stamp counter and the report_axis/report_cycles capture registers are present.
REQ-028 When it is not defined, the stamp counter and capture registers are absent and report_axis and report_cycles are tied to 0; the FSM, deadlock_detected and report_valid behave identically in both builds.

Verification (THRESHOLD=4, macro defined)
REQ-029 Reset released at cycle 0; block_in=1 from cycle 10, axis_block_sigs=3'b010 -> deadlock_detected=1 and report_valid=1 at cycle 14; report_axis=3'b010; report_cycles=13.
REQ-030 block_in high for cycles 10-12, low at 13, high from 14 -> no detection at 14; detection at 18.
REQ-031 After detection, report_ack pulsed at cycle 20 -> report_valid=0 at 21; deadlock_detected remains 1 while block_in toggles.
REQ-032 clear and report_ack asserted together in REPORT -> state IDLE next cycle; both flags 0; report_axis retained.
REQ-033 reset asserted mid-COUNT (cnt=2) -> all outputs 0 next cycle; a fresh 4-cycle run is needed for detection.
REQ-034 Macro undefined, scenario REQ-029 rerun -> identical flag timing; report_axis=0 and report_cycles=0.
